pipe_control: RTL and testbench
===============================

# pipe_control

Pipelined control unit for the five-stage RISC-V core. Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and produces the stall signal. Generates EX-stage forwarding selects and inserts bubbles on stall or branch flush. Replaces the purely combinational decoder with one block that owns all pipelined control state.

## Interface
Parameters:
- REGW, 5, register-address width
- ALUOPW, 2, ALUOp width (≥2; bits above [1:0] driven 0)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- Op_i  in  7  ID-stage opcode
- Valid_i  in  1  ID-stage instruction valid
- RS1_i  in  REGW  ID-stage rs1
- RS2_i  in  REGW  ID-stage rs2
- RD_i  in  REGW  ID-stage rd
- Flush_i  in  1  branch taken; squash the instruction now in ID
- Stall_o  out  1  load-use stall: hold PC and IF/ID
- ALUOp_o  out  ALUOPW  EX-stage ALU operation class
- ALUSrc_o  out  1  EX-stage: 1 = immediate operand
- Branch_o  out  1  EX-stage branch
- ForwardA_o, ForwardB_o  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- MemRead_o, MemWrite_o  out  1 each  MEM-stage controls
- MemtoReg_o, RegWrite_o  out  1 each  WB-stage controls
- WBRd_o  out  REGW  WB-stage destination register

## Operation
Decode (combinational, ID). Each class sets ALUOp/ALUSrc; the remaining bits are 1 where listed, 0 otherwise:
- 0110011 (R): ALUOp 10, ALUSrc 0; RegWrite
- 0010011 (I-ALU): ALUOp 11, ALUSrc 1; RegWrite
- 0000011 (load): ALUOp 00, ALUSrc 1; MemRead, MemtoReg, RegWrite
- 0100011 (store): ALUOp 00, ALUSrc 1; MemWrite
- 1100011 (branch): ALUOp 01, ALUSrc 0; Branch
- Any other opcode, or Valid_i=0: all-zero bundle (bubble)

Pipeline registers:
- ID/EX holds the bundle plus rs1, rs2 and rd.
- EX/MEM and MEM/WB hold the remaining control bits plus rd.

Hazard rule:
- hz = Valid_i & ID/EX.MemRead & (ID/EX.rd≠0) & (ID/EX.rd==RS1_i | ID/EX.rd==RS2_i)
- Stall_o = hz & ~Flush_i
- When hz or Flush_i is high, ID/EX loads a bubble. EX/MEM and MEM/WB always advance.

Forwarding, A (B identical, using ID/EX.rs2):
- 10 if EX/MEM.RegWrite & EX/MEM.rd≠0 & EX/MEM.rd==ID/EX.rs1
- else 01 if MEM/WB.RegWrite & WBRd≠0 & WBRd==ID/EX.rs1
- else 00
- EX/MEM has priority over MEM/WB.

## Timing
- Reset: every pipeline register clears to a bubble with rd=0, so all outputs read 0 during and immediately after reset. Reset mid-operation discards all in-flight control.
- Decode-to-output latency:
  - EX outputs one cycle after ID
  - MEM outputs two cycles after ID
  - WB outputs three cycles after ID
- Stall_o is combinational from the ID inputs and ID/EX state, with no register.
- A stall lasts exactly one cycle per load-use pair, because the bubble clears ID/EX.MemRead.
- Forward selects are combinational from registered state only, valid the whole EX cycle.
- Flush_i together with hz: bubble inserted, Stall_o=0 (flush wins).
- rd=x0 never forwards and never stalls.

## Structure
- Shared package (ctrl_pkg):
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - ALUOp encodings (ALU_ADD=00, ALU_SUB=01, ALU_R=10, ALU_I=11)
  - forward-select encodings (FWD_RF, FWD_MEM, FWD_WB)
  - packed struct typedef ctrl_bundle_t
- One sub-module: ctrl_decode, the combinational opcode-to-bundle decoder.
- Hazard logic, forwarding logic and pipeline registers stay in pipe_control.

## Test plan
- Reset: drive rst_i=0 mid-stream, then release → all outputs 0; first valid R-type gives ALUOp_o=10, ALUSrc_o=0 one cycle later and RegWrite_o=1 three cycles later.
- Each opcode plus 1111111, with Valid_i=1 → EX/MEM/WB outputs match the decode list at +1/+2/+3 cycles; 1111111 gives all zeros.
- Load-use: `lw x5` followed by `add x6,x5,x7` → Stall_o=1 for exactly one cycle, bubble reaches EX, then ForwardA_o=01 for the add.
- Forwarding: back-to-back `add x3,..` then `sub x4,x3,x3` → ForwardA_o=ForwardB_o=10. Same pair with rd=x0 → 00.
- Double hazard: x3 written by both EX/MEM and MEM/WB → select 10 (priority).
- Flush during load-use hazard: Flush_i=1 with hz=1 → Stall_o=0, ID/EX is a bubble, and no MemWrite/RegWrite appears downstream from the squashed instruction.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALUOp/forward encodings and the control bundle shared by the pipeline control logic.
package ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_bundle_t;
    localparam ctrl_bundle_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational ID-stage opcode to control bundle; invalid or unknown opcodes give a bubble.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   Op_i,
    input  logic         Valid_i,
    output ctrl_bundle_t Ctrl_o
);
    always_comb begin
        Ctrl_o = CTRL_BUBBLE;
        if (Valid_i) begin
            case (Op_i)
                OP_R: begin
                    Ctrl_o.aluop    = ALU_R;
                    Ctrl_o.regwrite = 1'b1;
                end
                OP_I: begin
                    Ctrl_o.aluop    = ALU_I;
                    Ctrl_o.alusrc   = 1'b1;
                    Ctrl_o.regwrite = 1'b1;
                end
                OP_LOAD: begin
                    Ctrl_o.aluop    = ALU_ADD;
                    Ctrl_o.alusrc   = 1'b1;
                    Ctrl_o.memread  = 1'b1;
                    Ctrl_o.memtoreg = 1'b1;
                    Ctrl_o.regwrite = 1'b1;
                end
                OP_STORE: begin
                    Ctrl_o.aluop    = ALU_ADD;
                    Ctrl_o.alusrc   = 1'b1;
                    Ctrl_o.memwrite = 1'b1;
                end
                OP_BRANCH: begin
                    Ctrl_o.aluop  = ALU_SUB;
                    Ctrl_o.branch = 1'b1;
                end
                default: Ctrl_o = CTRL_BUBBLE;
            endcase
        end
    end
endmodule

// File: rtl/pipe_control.sv
// pipe_control: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB,
// and owns load-use stall, bubble insertion and EX forwarding selects.
module pipe_control
    import ctrl_pkg::*;
#(
    parameter int REGW   = 5,
    parameter int ALUOPW = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [6:0]        Op_i,
    input  logic              Valid_i,
    input  logic [REGW-1:0]   RS1_i,
    input  logic [REGW-1:0]   RS2_i,
    input  logic [REGW-1:0]   RD_i,
    input  logic              Flush_i,
    output logic              Stall_o,
    output logic [ALUOPW-1:0] ALUOp_o,
    output logic              ALUSrc_o,
    output logic              Branch_o,
    output logic [1:0]        ForwardA_o,
    output logic [1:0]        ForwardB_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic [REGW-1:0]   WBRd_o
);
    ctrl_bundle_t    w_dec;
    ctrl_bundle_t    r_idex;
    logic [REGW-1:0] r_idex_rs1, r_idex_rs2, r_idex_rd;
    logic            r_exmem_mr, r_exmem_mw, r_exmem_m2r, r_exmem_rw;
    logic [REGW-1:0] r_exmem_rd;
    logic            r_memwb_m2r, r_memwb_rw;
    logic [REGW-1:0] r_memwb_rd;
    logic            w_hz, w_bubble, w_mem_ok, w_wb_ok;

    ctrl_decode u_dec (
        .Op_i    (Op_i),
        .Valid_i (Valid_i),
        .Ctrl_o  (w_dec)
    );

    assign w_hz     = Valid_i & r_idex.memread & (r_idex_rd != '0) &
                      ((r_idex_rd == RS1_i) | (r_idex_rd == RS2_i));
    assign w_bubble = w_hz | Flush_i | ~Valid_i;
    assign Stall_o  = w_hz & ~Flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idex      <= CTRL_BUBBLE;
            r_idex_rs1  <= '0;
            r_idex_rs2  <= '0;
            r_idex_rd   <= '0;
            r_exmem_mr  <= 1'b0;
            r_exmem_mw  <= 1'b0;
            r_exmem_m2r <= 1'b0;
            r_exmem_rw  <= 1'b0;
            r_exmem_rd  <= '0;
            r_memwb_m2r <= 1'b0;
            r_memwb_rw  <= 1'b0;
            r_memwb_rd  <= '0;
        end else begin
            r_idex      <= w_bubble ? CTRL_BUBBLE : w_dec;
            r_idex_rs1  <= w_bubble ? '0 : RS1_i;
            r_idex_rs2  <= w_bubble ? '0 : RS2_i;
            r_idex_rd   <= w_bubble ? '0 : RD_i;
            r_exmem_mr  <= r_idex.memread;
            r_exmem_mw  <= r_idex.memwrite;
            r_exmem_m2r <= r_idex.memtoreg;
            r_exmem_rw  <= r_idex.regwrite;
            r_exmem_rd  <= r_idex_rd;
            r_memwb_m2r <= r_exmem_m2r;
            r_memwb_rw  <= r_exmem_rw;
            r_memwb_rd  <= r_exmem_rd;
        end
    end

    // x0 is never a forwarding source; EX/MEM wins over MEM/WB
    assign w_mem_ok   = r_exmem_rw & (r_exmem_rd != '0);
    assign w_wb_ok    = r_memwb_rw & (r_memwb_rd != '0);
    assign ForwardA_o = (w_mem_ok && r_exmem_rd == r_idex_rs1) ? FWD_MEM :
                        (w_wb_ok && r_memwb_rd == r_idex_rs1) ? FWD_WB : FWD_RF;
    assign ForwardB_o = (w_mem_ok && r_exmem_rd == r_idex_rs2) ? FWD_MEM :
                        (w_wb_ok && r_memwb_rd == r_idex_rs2) ? FWD_WB : FWD_RF;

    assign ALUOp_o    = ALUOPW'(r_idex.aluop);
    assign ALUSrc_o   = r_idex.alusrc;
    assign Branch_o   = r_idex.branch;
    assign MemRead_o  = r_exmem_mr;
    assign MemWrite_o = r_exmem_mw;
    assign MemtoReg_o = r_memwb_m2r;
    assign RegWrite_o = r_memwb_rw;
    assign WBRd_o     = r_memwb_rd;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: instruction-level pipeline model feeds a scoreboard queue; a negedge monitor compares every cycle.
module tb_pipe_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] Op_i = '0;
    logic       Valid_i = 1'b0;
    logic [4:0] RS1_i = '0, RS2_i = '0, RD_i = '0;
    logic       Flush_i = 1'b0;
    logic       Stall_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o;
    logic [1:0] ALUOp_o, ForwardA_o, ForwardB_o;
    logic [4:0] WBRd_o;

    pipe_control #(.REGW(5), .ALUOPW(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .Op_i(Op_i), .Valid_i(Valid_i),
        .RS1_i(RS1_i), .RS2_i(RS2_i), .RD_i(RD_i), .Flush_i(Flush_i),
        .Stall_o(Stall_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o),
        .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .WBRd_o(WBRd_o)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011, BAD = 7'b1111111;

    typedef struct packed {logic v; logic [6:0] op; logic [4:0] rs1, rs2, rd;} ins_t;
    typedef struct packed {logic [1:0] aluop; logic alusrc, branch, mr, mw, m2r, rw;} ctl_t;
    typedef struct packed {
        logic stall; logic [1:0] aluop; logic alusrc, branch; logic [1:0] fa, fb;
        logic mr, mw, m2r, rw; logic [4:0] wbrd;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    ins_t m_ex = '0, m_mem = '0, m_wb = '0;
    int checks = 0, errors = 0, ncyc = 0;
    logic [6:0] ops [0:5] = '{R, I, LD, ST, BR, BAD};

    // Control table as listed for each instruction class
    function automatic ctl_t ctl(input ins_t x);
        if (!x.v) return '0;
        case (x.op)
            R:       return 8'b10_0_0_0_0_0_1;
            I:       return 8'b11_1_0_0_0_0_1;
            LD:      return 8'b00_1_0_1_0_1_1;
            ST:      return 8'b00_1_0_0_1_0_0;
            BR:      return 8'b01_0_1_0_0_0_0;
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (ctl(m_mem).rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (ctl(m_wb).rw && m_wb.rd != 0 && m_wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic hazard(input ins_t id);
        return id.v && ctl(m_ex).mr && m_ex.rd != 0 && (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
    endfunction

    function automatic obs_t predict(input ins_t id, input logic fl);
        obs_t o;
        ctl_t ce = ctl(m_ex), cm = ctl(m_mem), cw = ctl(m_wb);
        o.stall = hazard(id) && !fl;
        o.aluop = ce.aluop; o.alusrc = ce.alusrc; o.branch = ce.branch;
        o.fa = fwd(m_ex.rs1); o.fb = fwd(m_ex.rs2);
        o.mr = cm.mr; o.mw = cm.mw; o.m2r = cw.m2r; o.rw = cw.rw;
        o.wbrd = m_wb.rd;
        return o;
    endfunction

    // Present one ID instruction; re-present it while the pipeline stalls (IF/ID held)
    task automatic issue(input logic v, input logic [6:0] op, input logic [4:0] rs1, rs2, rd, input logic fl);
        ins_t id;
        obs_t e;
        logic hz;
        id = {v, op, rs1, rs2, rd};
        for (int k = 0; k < 3; k++) begin
            Valid_i = v; Op_i = op; RS1_i = rs1; RS2_i = rs2; RD_i = rd; Flush_i = fl;
            e = predict(id, fl);
            hz = hazard(id);
            exp_q.push_back(e);
            @(posedge clk); #1;
            m_wb = m_mem; m_mem = m_ex;
            m_ex = (v && !hz && !fl) ? id : '0;
            if (!e.stall) return;
        end
        checks++; errors++;
        $display("FAIL stall-bound: stall persisted %0d cycles, required at most 1", 3);
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; Valid_i = 1'b0; Flush_i = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        repeat (n) begin
            exp_q.push_back('0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {Stall_o, ALUOp_o, ALUSrc_o, Branch_o, ForwardA_o, ForwardB_o,
                     MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o, WBRd_o};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL cycle%0d outputs {stall,aluop,alusrc,br,fa,fb,mr,mw,m2r,rw,wbrd}: got %b required %b",
                         ncyc, mon_a, mon_e);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        do_reset(3);
        issue(1, R, 5'd2, 5'd3, 5'd1, 0); idle(3);
        for (int k = 0; k < 6; k++) issue(1, ops[k], 5'd1, 5'd2, 5'(9 + k), 0);
        idle(3);
        issue(1, LD, 5'd1, 5'd0, 5'd5, 0); issue(1, R, 5'd5, 5'd7, 5'd6, 0); idle(3);
        issue(1, R, 5'd1, 5'd2, 5'd3, 0); issue(1, R, 5'd3, 5'd3, 5'd4, 0); idle(3);
        issue(1, R, 5'd1, 5'd2, 5'd0, 0); issue(1, R, 5'd0, 5'd0, 5'd4, 0); idle(3);
        issue(1, R, 5'd1, 5'd2, 5'd3, 0); issue(1, I, 5'd1, 5'd0, 5'd3, 0);
        issue(1, R, 5'd3, 5'd3, 5'd4, 0); idle(3);
        issue(1, LD, 5'd1, 5'd0, 5'd5, 0); issue(1, R, 5'd5, 5'd7, 5'd6, 1);
        issue(1, ST, 5'd5, 5'd6, 5'd0, 1); idle(3);
        issue(1, LD, 5'd1, 5'd0, 5'd8, 0); issue(1, R, 5'd2, 5'd3, 5'd9, 0);
        do_reset(2);
        issue(1, R, 5'd1, 5'd2, 5'd3, 0); idle(3);
        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            if (n == 200) do_reset(1);
            issue($urandom_range(0, 7) != 0, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
        end
        idle(3);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
